// File: rtl/spi_pkg.sv
// spi_pkg: shared state encoding and constants for the SPI transfer sequencer
package spi_pkg;
  localparam int SPI_BYTE_W = 8;
  localparam int DEF_LEN_W = 4;
  typedef enum logic [2:0] {IDLE, SETUP, FETCH, XFER, GAP, HOLD} state_t;
  // the shared down-counter must hold setup, hold and the 4-bit gap
  function automatic int cnt_width(input int setup_cyc, input int hold_cyc);
    int m;
    m = setup_cyc > hold_cyc ? setup_cyc : hold_cyc;
    m = m > 15 ? m : 15;
    return $clog2(m + 1);
  endfunction
endpackage

// File: rtl/spi_rx_hold_reg.sv
// spi_rx_hold_reg: one-entry valid/ready output register
module spi_rx_hold_reg #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_data,
  output logic         valid,
  input  logic         ready,
  output logic [W-1:0] data
);
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      valid <= 1'b0;
      data <= '0;
    end else begin
      valid <= load || (valid && !ready);
      if (load) data <= load_data;
    end
endmodule

// File: rtl/spi_xfer_sequencer.sv
// spi_xfer_sequencer: frames multi-byte SPI commands around a byte-level engine
module spi_xfer_sequencer
  import spi_pkg::*;
#(
  parameter int LEN_W = DEF_LEN_W,
  parameter int SETUP_CYC = 2,
  parameter int HOLD_CYC = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_sel,
  input  logic [LEN_W-1:0]      cmd_len,
  input  logic [3:0]            cmd_gap,
  input  logic                  tx_valid,
  output logic                  tx_ready,
  input  logic [SPI_BYTE_W-1:0] tx_data,
  output logic                  rx_valid,
  input  logic                  rx_ready,
  output logic [SPI_BYTE_W-1:0] rx_data,
  output logic                  eng_start,
  output logic [SPI_BYTE_W-1:0] eng_tx,
  input  logic                  eng_busy,
  input  logic                  eng_done,
  input  logic [SPI_BYTE_W-1:0] eng_rx,
  output logic                  ss0,
  output logic                  ss1,
  output logic                  xfer_active,
  output logic                  xfer_done
);
  localparam int CNT_W = cnt_width(SETUP_CYC, HOLD_CYC);
  state_t state;
  logic [LEN_W:0] remaining;
  logic [3:0] gap;
  logic [CNT_W-1:0] cnt;
  logic rx_load;
  logic cnt_last;
  assign cmd_ready = state == IDLE;
  assign tx_ready = state == FETCH && !eng_busy && (!rx_valid || rx_ready);
  assign rx_load = state == XFER && eng_done;
  assign xfer_active = !(ss0 && ss1);
  assign cnt_last = cnt == CNT_W'(1);
  spi_rx_hold_reg #(.W(SPI_BYTE_W)) u_rx (
    .clk(clk),
    .rst(rst),
    .load(rx_load),
    .load_data(eng_rx),
    .valid(rx_valid),
    .ready(rx_ready),
    .data(rx_data)
  );
  // counter is loaded with N and the state exits on 1, so each wait lasts N cycles
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      remaining <= '0;
      gap <= '0;
      cnt <= '0;
      eng_start <= 1'b0;
      eng_tx <= '0;
      ss0 <= 1'b1;
      ss1 <= 1'b1;
      xfer_done <= 1'b0;
    end else begin
      eng_start <= 1'b0;
      xfer_done <= 1'b0;
      case (state)
        IDLE: if (cmd_valid) begin
          remaining <= cmd_len == '0 ? {1'b1, {LEN_W{1'b0}}} : {1'b0, cmd_len};
          gap <= cmd_gap;
          ss0 <= cmd_sel;
          ss1 <= !cmd_sel;
          cnt <= CNT_W'(SETUP_CYC);
          state <= SETUP;
        end
        SETUP: if (cnt_last) state <= FETCH; else cnt <= cnt - 1'b1;
        FETCH: if (tx_valid && tx_ready) begin
          eng_tx <= tx_data;
          eng_start <= 1'b1;
          state <= XFER;
        end
        XFER: if (eng_done) begin
          remaining <= remaining - 1'b1;
          if (remaining == (LEN_W+1)'(1)) begin
            cnt <= CNT_W'(HOLD_CYC);
            state <= HOLD;
          end else if (gap != '0) begin
            cnt <= CNT_W'(gap);
            state <= GAP;
          end else state <= FETCH;
        end
        GAP: if (cnt_last) state <= FETCH; else cnt <= cnt - 1'b1;
        HOLD: if (cnt_last) begin
          ss0 <= 1'b1;
          ss1 <= 1'b1;
          xfer_done <= 1'b1;
          state <= IDLE;
        end else cnt <= cnt - 1'b1;
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_spi_xfer_sequencer.sv
// tb_spi_xfer_sequencer: randomized frames against an engine model and frame-level reference
module tb_spi_xfer_sequencer;
  localparam int LEN_W = 4;
  localparam int SETUP = 2;
  localparam int HOLD = 2;
  logic clk = 0, rst = 0;
  logic cmd_valid = 0, cmd_ready, cmd_sel = 0;
  logic [LEN_W-1:0] cmd_len = '0;
  logic [3:0] cmd_gap = '0;
  logic tx_valid = 0, tx_ready;
  logic [7:0] tx_data = '0;
  logic rx_valid, rx_ready = 0;
  logic [7:0] rx_data;
  logic eng_start;
  logic [7:0] eng_tx;
  logic eng_busy = 0, eng_done = 0;
  logic [7:0] eng_rx = '0;
  logic ss0, ss1, xfer_active, xfer_done;
  int checks = 0, failures = 0;
  int cyc = 0, starts = 0, xdone = 0, both_low = 0, act_bad = 0, eng_unstable = 0;
  int eng_lat = 4, busy_cnt = 0;
  bit rx_hold = 0, rx_rand = 0, spur = 0, hs_tx, hs_rx;
  logic [7:0] spur_data = '0, cur = '0;
  logic [7:0] tx_src[$], eng_seen[$], rx_got[$];
  int start_cyc[$], done_cyc[$];

  spi_xfer_sequencer #(.LEN_W(LEN_W), .SETUP_CYC(SETUP), .HOLD_CYC(HOLD)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_sel(cmd_sel),
    .cmd_len(cmd_len), .cmd_gap(cmd_gap), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .tx_data(tx_data), .rx_valid(rx_valid), .rx_ready(rx_ready), .rx_data(rx_data),
    .eng_start(eng_start), .eng_tx(eng_tx), .eng_busy(eng_busy), .eng_done(eng_done),
    .eng_rx(eng_rx), .ss0(ss0), .ss1(ss1), .xfer_active(xfer_active), .xfer_done(xfer_done)
  );

  initial forever #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  // engine, TX source and RX sink model; engine answers each byte with byte ^ 0x99
  initial forever begin
    @(negedge clk);
    hs_tx = !rst && tx_valid && tx_ready;
    hs_rx = !rst && rx_valid && rx_ready;
    if (hs_rx) rx_got.push_back(rx_data);
    if (!rst) begin
      if (ss0 === 1'b0 && ss1 === 1'b0) both_low++;
      if (xfer_active !== !(ss0 && ss1)) act_bad++;
      if (xfer_done === 1'b1) xdone++;
    end
    @(posedge clk);
    cyc++;
    #1;
    if (hs_tx) void'(tx_src.pop_front());
    tx_valid = tx_src.size() != 0;
    tx_data = tx_valid ? tx_src[0] : 8'h00;
    rx_ready = !rx_hold && (!rx_rand || $urandom_range(0, 1) == 1);
    eng_done = 1'b0;
    if (rst) begin
      busy_cnt = 0;
      eng_busy = 0;
    end else begin
      if (busy_cnt > 0) begin
        busy_cnt--;
        if (busy_cnt == 0) begin
          if (eng_tx !== cur) eng_unstable++;
          eng_busy = 0;
          eng_done = 1;
          eng_rx = cur ^ 8'h99;
          done_cyc.push_back(cyc);
        end
      end
      if (spur) begin
        eng_done = 1;
        eng_rx = spur_data;
        spur = 0;
      end
      if (eng_start === 1'b1) begin
        starts++;
        cur = eng_tx;
        eng_seen.push_back(eng_tx);
        start_cyc.push_back(cyc);
        eng_busy = 1;
        busy_cnt = eng_lat;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic tick_s();
    @(negedge clk);
    #1;
  endtask

  task automatic clear_logs();
    start_cyc.delete();
    done_cyc.delete();
    eng_seen.delete();
    rx_got.delete();
    xdone = 0;
  endtask

  task automatic issue(input bit sel, input int len, input int gap, output int t);
    int k;
    k = 0;
    while (!cmd_ready && k < 200) begin tick(); k++; end
    cmd_sel = sel;
    cmd_len = LEN_W'(len);
    cmd_gap = 4'(gap);
    cmd_valid = 1;
    t = cyc;
    tick();
    cmd_valid = 0;
  endtask

  task automatic wait_done(output int x);
    int k;
    k = 0;
    do begin tick_s(); k++; end while (xfer_done !== 1'b1 && k < 3000);
    x = cyc;
  endtask

  task automatic do_frame(input bit sel, input int len, input int gap, input logic [7:0] bytes[$], input string name);
    int n, t, x, k, ss_hi, other_lo, bad;
    n = len == 0 ? 16 : len;
    clear_logs();
    foreach (bytes[i]) tx_src.push_back(bytes[i]);
    issue(sel, len, gap, t);
    checks++;
    if ((sel ? ss1 : ss0) !== 1'b0) begin failures++; $display("FAIL %s ss_assert: got %b want 0", name, sel ? ss1 : ss0); end
    ss_hi = 0; other_lo = 0; k = 0;
    do begin
      tick_s(); k++;
      if (xfer_done !== 1'b1 && (sel ? ss1 : ss0) !== 1'b0) ss_hi++;
      if ((sel ? ss0 : ss1) !== 1'b1) other_lo++;
    end while (xfer_done !== 1'b1 && k < 3000);
    x = cyc;
    checks++;
    if (xfer_done !== 1'b1) begin failures++; $display("FAIL %s xfer_done_timeout: got %b want 1", name, xfer_done); end
    checks++;
    if (ss_hi != 0 || other_lo != 0) begin failures++; $display("FAIL %s ss_frame: sel_high=%0d other_low=%0d want 0/0", name, ss_hi, other_lo); end
    checks++;
    if (done_cyc.size() != n || x != done_cyc[n-1] + 1 + HOLD) begin
      failures++; $display("FAIL %s hold_timing: dones=%0d done_at=%0d want %0d dones, at last_done+%0d", name, done_cyc.size(), x, n, 1 + HOLD);
    end
    checks++;
    if ({ss0, ss1, cmd_ready} !== 3'b111) begin failures++; $display("FAIL %s frame_end: ss0,ss1,cmd_ready=%b want 111", name, {ss0, ss1, cmd_ready}); end
    checks++;
    if (start_cyc.size() == 0 || start_cyc[0] != t + 2 + SETUP) begin failures++; $display("FAIL %s first_start: got %0d want %0d", name, start_cyc.size() ? start_cyc[0] - t : -1, 2 + SETUP); end
    bad = 0;
    for (int i = 0; i + 1 < start_cyc.size() && i < done_cyc.size(); i++) if (start_cyc[i+1] < done_cyc[i] + 2 + gap) bad++;
    checks++;
    if (bad != 0) begin failures++; $display("FAIL %s gap_spacing: short gaps=%0d want 0", name, bad); end
    k = 0;
    while (rx_got.size() < n && k < 200) begin tick_s(); k++; end
    bad = 0;
    for (int i = 0; i < n; i++) begin
      if (i >= eng_seen.size() || eng_seen[i] !== bytes[i]) bad++;
      if (i >= rx_got.size() || rx_got[i] !== (bytes[i] ^ 8'h99)) bad++;
    end
    checks++;
    if (bad != 0 || eng_seen.size() != n || rx_got.size() != n) begin
      failures++; $display("FAIL %s data: bad=%0d tx_bytes=%0d rx_bytes=%0d want 0/%0d/%0d", name, bad, eng_seen.size(), rx_got.size(), n, n);
    end
    checks++;
    if (xdone != 1) begin failures++; $display("FAIL %s done_pulses: got %0d want 1", name, xdone); end
  endtask

  task automatic test_reset();
    #2 rst = 1;
    #1;
    checks++;
    if ({cmd_ready, tx_ready, rx_valid, eng_start, ss0, ss1, xfer_active, xfer_done} !== 8'b10001100 || rx_data !== 8'h00 || eng_tx !== 8'h00) begin
      failures++; $display("FAIL reset_values: flags=%b rx_data=%h eng_tx=%h want 10001100/00/00",
        {cmd_ready, tx_ready, rx_valid, eng_start, ss0, ss1, xfer_active, xfer_done}, rx_data, eng_tx);
    end
    repeat (3) tick();
    tick_s();
    rst = 0;
  endtask

  task automatic test_reset_mid_xfer();
    int t, k, s0;
    clear_logs();
    eng_lat = 10;
    rx_rand = 0;
    repeat (4) tx_src.push_back(8'($urandom));
    issue(0, 4, 0, t);
    k = 0;
    while (start_cyc.size() < 2 && k < 300) begin tick_s(); k++; end
    tick_s();
    tick_s();
    #2 rst = 1;
    #1;
    checks++;
    if ({ss0, ss1, rx_valid, xfer_active} !== 4'b1100) begin failures++; $display("FAIL reset_mid: ss0,ss1,rx_valid,active=%b want 1100 starts=%0d", {ss0, ss1, rx_valid, xfer_active}, start_cyc.size()); end
    tx_src.delete();
    tick();
    tick();
    tick_s();
    rst = 0;
    s0 = starts;
    repeat (12) tick_s();
    checks++;
    if (cmd_ready !== 1'b1 || starts != s0 || ss0 !== 1'b1) begin failures++; $display("FAIL reset_recover: cmd_ready=%b new_starts=%0d ss0=%b want 1/0/1", cmd_ready, starts - s0, ss0); end
  endtask

  task automatic test_single();
    logic [7:0] b[$];
    eng_lat = 16;
    b = '{8'hA5};
    do_frame(0, 1, 0, b, "single");
    checks++;
    if (rx_got.size() != 1 || rx_got[0] !== 8'h3C) begin failures++; $display("FAIL single_rx: got %h want 3c", rx_got.size() ? rx_got[0] : 8'hxx); end
  endtask

  task automatic test_gap();
    logic [7:0] b[$];
    eng_lat = 3;
    b = '{8'h01, 8'h02, 8'h03};
    do_frame(1, 3, 4, b, "gap4");
  endtask

  task automatic test_len_zero();
    logic [7:0] b[$];
    eng_lat = 2;
    for (int i = 0; i < 16; i++) b.push_back(8'($urandom));
    do_frame(0, 0, 1, b, "len0");
  endtask

  task automatic test_rx_backpressure();
    logic [7:0] b[$];
    int t, x, k, tr_hi;
    clear_logs();
    eng_lat = 3;
    rx_rand = 0;
    b = '{8'($urandom), 8'($urandom)};
    foreach (b[i]) tx_src.push_back(b[i]);
    tick_s();
    rx_hold = 1;
    issue(0, 2, 0, t);
    k = 0;
    while (done_cyc.size() < 1 && k < 100) begin tick_s(); k++; end
    tr_hi = 0;
    repeat (30) begin tick_s(); if (tx_ready !== 1'b0) tr_hi++; end
    checks++;
    if (tr_hi != 0 || start_cyc.size() != 1 || rx_valid !== 1'b1) begin failures++; $display("FAIL bp_stall: tx_ready_high=%0d starts=%0d rx_valid=%b want 0/1/1", tr_hi, start_cyc.size(), rx_valid); end
    rx_hold = 0;
    wait_done(x);
    k = 0;
    while (rx_got.size() < 2 && k < 50) begin tick_s(); k++; end
    checks++;
    if (rx_got.size() != 2 || rx_got[0] !== (b[0] ^ 8'h99) || rx_got[1] !== (b[1] ^ 8'h99) || start_cyc.size() != 2) begin
      failures++; $display("FAIL bp_resume: rx_bytes=%0d starts=%0d want 2/2", rx_got.size(), start_cyc.size());
    end
  endtask

  task automatic test_spurious();
    logic [7:0] b[$], d0;
    int t, x, k;
    tick_s();
    d0 = rx_data;
    spur_data = 8'h5A;
    spur = 1;
    repeat (3) tick_s();
    checks++;
    if (rx_valid !== 1'b0 || rx_data !== d0 || cmd_ready !== 1'b1) begin failures++; $display("FAIL spur_idle: rx_valid=%b rx_data=%h want 0/%h", rx_valid, rx_data, d0); end
    clear_logs();
    eng_lat = 3;
    b = '{8'($urandom), 8'($urandom)};
    foreach (b[i]) tx_src.push_back(b[i]);
    rx_hold = 1;
    issue(1, 2, 8, t);
    k = 0;
    while (done_cyc.size() < 1 && k < 100) begin tick_s(); k++; end
    spur_data = ~(b[0] ^ 8'h99);
    spur = 1;
    tick_s();
    tick_s();
    checks++;
    if (rx_valid !== 1'b1 || rx_data !== (b[0] ^ 8'h99) || start_cyc.size() != 1) begin
      failures++; $display("FAIL spur_gap: rx_valid=%b rx_data=%h starts=%0d want 1/%h/1", rx_valid, rx_data, start_cyc.size(), b[0] ^ 8'h99);
    end
    rx_hold = 0;
    wait_done(x);
    k = 0;
    while (rx_got.size() < 2 && k < 50) begin tick_s(); k++; end
    repeat (3) tick_s();
    checks++;
    if (rx_got.size() != 2 || rx_got[0] !== (b[0] ^ 8'h99) || rx_got[1] !== (b[1] ^ 8'h99) || eng_seen.size() != 2) begin
      failures++; $display("FAIL spur_frame: rx_bytes=%0d tx_bytes=%0d want 2/2", rx_got.size(), eng_seen.size());
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] a[$], b[$];
    int k, x;
    clear_logs();
    eng_lat = 3;
    rx_rand = 0;
    a = '{8'($urandom), 8'($urandom)};
    b = '{8'($urandom), 8'($urandom), 8'($urandom)};
    foreach (a[i]) tx_src.push_back(a[i]);
    foreach (b[i]) tx_src.push_back(b[i]);
    k = 0;
    while (!cmd_ready && k < 100) begin tick(); k++; end
    cmd_sel = 0; cmd_len = 2; cmd_gap = 1; cmd_valid = 1;
    tick();
    cmd_sel = 1; cmd_len = 3; cmd_gap = 0;
    wait_done(x);
    checks++;
    if ({xfer_done, cmd_ready, cmd_valid} !== 3'b111) begin failures++; $display("FAIL b2b_accept: done,ready,valid=%b want 111", {xfer_done, cmd_ready, cmd_valid}); end
    tick();
    cmd_valid = 0;
    checks++;
    if ({ss0, ss1} !== 2'b10) begin failures++; $display("FAIL b2b_reassert: ss0,ss1=%b want 10", {ss0, ss1}); end
    wait_done(x);
    k = 0;
    while (rx_got.size() < 5 && k < 50) begin tick_s(); k++; end
    checks++;
    if (xdone != 2 || rx_got.size() != 5 || eng_seen.size() != 5 || rx_got[1] !== (a[1] ^ 8'h99) || rx_got[2] !== (b[0] ^ 8'h99) || rx_got[4] !== (b[2] ^ 8'h99)) begin
      failures++; $display("FAIL b2b_frames: done_pulses=%0d rx_bytes=%0d tx_bytes=%0d want 2/5/5", xdone, rx_got.size(), eng_seen.size());
    end
  endtask

  task automatic test_random();
    logic [7:0] b[$];
    int len, n;
    bit sel;
    rx_rand = 1;
    for (int f = 0; f < 5; f++) begin
      b.delete();
      sel = 1'($urandom);
      len = $urandom_range(0, 15);
      n = len == 0 ? 16 : len;
      eng_lat = $urandom_range(1, 8);
      for (int i = 0; i < n; i++) b.push_back(8'($urandom));
      do_frame(sel, len, $urandom_range(0, 5), b, $sformatf("rand%0d", f));
    end
    rx_rand = 0;
  endtask

  task automatic test_invariants();
    checks++;
    if (both_low != 0 || act_bad != 0 || eng_unstable != 0) begin
      failures++; $display("FAIL invariants: both_low=%0d active_bad=%0d eng_tx_unstable=%0d want 0/0/0", both_low, act_bad, eng_unstable);
    end
  endtask

  initial begin
    test_reset();
    test_reset_mid_xfer();
    test_single();
    test_gap();
    test_len_zero();
    test_rx_backpressure();
    test_spurious();
    test_back_to_back();
    test_random();
    test_invariants();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
